mul_seq: RTL

- Iterative radix-2 shift-add multiplier for the CPU EX stage.
- Counterpart to the restoring divider; shares its start/done/match interface so EX drives both units identically.
- Implements RISC-V MUL, MULH, MULHSU and MULHU; one instance per datapath width (32b and 64b).
- Takes one multiplier bit per cycle; the full 2*MULLEN-bit product is available when done.

---
 rtl/mul_seq.sv | 92 +++++++++
 1 files changed

// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier for RISC-V MUL/MULH/MULHSU/MULHU.
// It retires one multiplier bit per cycle. The full 2*MULLEN-bit product is held once done is high.
module mul_seq #(
    parameter int MULLEN = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        op,
    input  logic              start,
    input  logic [MULLEN-1:0] a,
    input  logic [MULLEN-1:0] b,
    output logic              done,
    output logic              match,
    output logic [MULLEN-1:0] lo,
    output logic [MULLEN-1:0] hi
);
    localparam int SW = $clog2(MULLEN + 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(MULLEN);

    logic [MULLEN:0]     acc_hi;
    logic [MULLEN-1:0]   acc_lo;
    logic [MULLEN-1:0]   mcand;
    logic                neg;
    logic [SW-1:0]       step;
    logic                valid;
    logic [MULLEN-1:0]   lat_a;
    logic [MULLEN-1:0]   lat_b;
    logic                lat_sa;
    logic                lat_sb;

    logic                op_sa;
    logic                op_sb;
    logic                neg_init;
    logic [MULLEN-1:0]   abs_a;
    logic [MULLEN-1:0]   abs_b;
    logic [MULLEN:0]     acc_sum;
    logic [2*MULLEN-1:0] prod_mag;
    logic [2*MULLEN-1:0] product;

    // MUL runs as unsigned x unsigned because the low half does not depend on signedness.
    always_comb begin
        op_sa    = (op == 2'd1) || (op == 2'd2);
        op_sb    = (op == 2'd1);
        abs_a    = (op_sa && a[MULLEN-1]) ? -a : a;
        abs_b    = (op_sb && b[MULLEN-1]) ? -b : b;
        neg_init = (op_sa && a[MULLEN-1]) ^ (op_sb && b[MULLEN-1]);
        acc_sum  = acc_lo[0] ? acc_hi + {1'b0, mcand} : acc_hi;
        prod_mag = {acc_hi[MULLEN-1:0], acc_lo};
        product  = neg ? -prod_mag : prod_mag;
    end

    // Handshake: a start in any cycle (busy or idle) loads the operands and restarts the unit.
    // done stays low until MULLEN steps have run. lo/hi are valid only while done is high.
    // match tells EX that the held result already answers the current op/a/b.
    assign done  = (step == LAST_STEP);
    assign lo    = product[MULLEN-1:0];
    assign hi    = product[2*MULLEN-1:MULLEN];
    assign match = valid && done && (a == lat_a) && (b == lat_b) &&
                   ((op == 2'd0) || ((op_sa == lat_sa) && (op_sb == lat_sb)));

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_hi <= '0;
            acc_lo <= '0;
            mcand  <= '0;
            neg    <= 1'b0;
            step   <= LAST_STEP;
            valid  <= 1'b0;
            lat_a  <= '0;
            lat_b  <= '0;
            lat_sa <= 1'b0;
            lat_sb <= 1'b0;
        end else if (start) begin
            acc_hi <= '0;
            acc_lo <= abs_b;
            mcand  <= abs_a;
            neg    <= neg_init;
            step   <= '0;
            valid  <= 1'b1;
            lat_a  <= a;
            lat_b  <= b;
            lat_sa <= op_sa;
            lat_sb <= op_sb;
        end else if (!done) begin
            // Conditional add, then shift {acc_hi, acc_lo} right by one with a zero entering at the top.
            acc_hi <= {1'b0, acc_sum[MULLEN:1]};
            acc_lo <= {acc_sum[0], acc_lo[MULLEN-1:1]};
            step   <= step + SW'(1);
        end
    end

endmodule
